// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker: sweeps every input vector of a combinational
// block, waits SETTLE cycles per vector, compares against a supplied table.
`timescale 1ns/1ps

module truth_table_checker #(
  parameter int N_IN         = 3,
  parameter int N_OUT        = 1,
  parameter int SETTLE       = 2,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [(2**N_IN)*N_OUT-1:0] exp_table,
  output logic [N_IN-1:0]            stim,
  input  logic [N_OUT-1:0]           dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_IN:0]              pass_count,
  output logic [N_IN:0]              fail_count,
  output logic                       first_fail_valid,
  output logic [N_IN-1:0]            first_fail_vec,
  output logic [N_OUT-1:0]           first_fail_got
);

  localparam int TBL_W = (2**N_IN) * N_OUT;
  localparam int IDX_W = (TBL_W > 1) ? $clog2(TBL_W) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN:0]    TALLY_ONE = (N_IN + 1)'(1);
  localparam logic [N_IN-1:0]  STIM_ONE  = N_IN'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [IDX_W-1:0] tbl_idx;
  logic [N_OUT-1:0] exp_out;
  logic             mismatch;
  logic             last_vec;
  logic             stop_now;
  logic             accept;

  assign tbl_idx  = IDX_W'(stim) * IDX_W'(N_OUT);
  assign exp_out  = exp_table[tbl_idx +: N_OUT];
  assign mismatch = (dut_out != exp_out);
  assign last_vec = &stim;
  assign stop_now = (STOP_ON_FAIL != 0) && mismatch;
  assign accept   = ((state == S_IDLE) || (state == S_DONE)) && start;

  // State register; busy/done are flopped from the next state so they come
  // straight off flops, with no decode glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
      state <= state_nxt;
      busy  <= (state_nxt == S_SETTLE) || (state_nxt == S_CHECK);
      done  <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_SETTLE;
      S_SETTLE:       if (settle_cnt == CNT_LAST) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (last_vec || stop_now) ? S_DONE : S_SETTLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pass = done && (fail_count == '0);
  end

  // Sweep datapath: stimulus, settle timer, tallies and first-failure capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stim             <= '0;
      settle_cnt       <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_got   <= '0;
    end else if (accept) begin
      stim             <= '0;
      settle_cnt       <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_got   <= '0;
    end else if (state == S_SETTLE) begin
      settle_cnt <= settle_cnt + CNT_ONE;
    end else if (state == S_CHECK) begin
      if (mismatch) begin
        fail_count <= fail_count + TALLY_ONE;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_vec   <= stim;
          first_fail_got   <= dut_out;
        end
      end else begin
        pass_count <= pass_count + TALLY_ONE;
      end
      // stim stays put when the sweep ends so DONE shows the last vector tried.
      if (state_nxt == S_SETTLE) begin
        stim       <= stim + STIM_ONE;
        settle_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Synthesizable, parametrised exhaustive checker for an N-input / M-output combinational block. It sweeps every input vector, waits a programmable settle time, compares the DUT output against a supplied truth table, and reports pass/fail counts and the first failing vector. It sits beside a combinational DUT in a bench or on-chip self-test wrapper. It replaces single-vector hand-written checks with full truth-table coverage.

## Interface
Parameters:
- `N_IN`, 3, number of DUT inputs (1..16)
- `N_OUT`, 1, number of DUT outputs (1..32)
- `SETTLE`, 2, clock cycles stimulus is held before sampling (≥1)
- `STOP_ON_FAIL`, 0, 1 = end sweep at first mismatch; 0 = sweep all vectors

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE
- `exp_table`  in  (2**N_IN)*N_OUT  expected outputs; entry for vector v is `exp_table[v*N_OUT +: N_OUT]`; must be stable while `busy`
- `stim`  out  N_IN  stimulus vector driven to DUT inputs (MSB = first DUT input)
- `dut_out`  in  N_OUT  DUT outputs
- `busy`  out  1  sweep in progress
- `done`  out  1  sweep finished; held until next accepted `start` or reset
- `pass`  out  1  `done` && `fail_count`==0
- `pass_count`  out  N_IN+1  vectors matched
- `fail_count`  out  N_IN+1  vectors mismatched
- `first_fail_valid`  out  1  a mismatch has been captured this sweep
- `first_fail_vec`  out  N_IN  stimulus of first mismatch
- `first_fail_got`  out  N_OUT  `dut_out` sampled at first mismatch

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + `start`=1 → SETTLE. On the same edge: `stim`=0, settle counter=0, counts and first-fail fields cleared, `done`=0.
- SETTLE: counter increments each cycle. After SETTLE cycles in this state → CHECK.
- CHECK (one cycle): compare `dut_out` with the table entry for `stim` at the edge leaving CHECK.
  - Match: `pass_count`++.
  - Mismatch: `fail_count`++. If `first_fail_valid`=0, capture `stim`/`dut_out` and set `first_fail_valid`.
- Leaving CHECK:
  - → DONE if `stim`==2**N_IN−1, or if `STOP_ON_FAIL`=1 and this vector mismatched.
  - Otherwise `stim`++, counter=0, → SETTLE.
- `start` while SETTLE/CHECK is ignored. No restart and no effect on counts.
- Counters are N_IN+1 bits, so 2**N_IN is representable and counters never wrap.
- `stim` holds its last value in DONE.
- Reset (any state, including mid-sweep) → IDLE immediately. All outputs 0, `stim`=0. A partial sweep is discarded.

## Timing
- `busy` = state is SETTLE or CHECK. `done` = state is DONE. Both are registered.
- Per vector: SETTLE+1 cycles.
- Full sweep: `start` sampled at edge E0, `done` rises at edge E0 + (2**N_IN)·(SETTLE+1).
- With `STOP_ON_FAIL`=1 and the first mismatch at vector k: `done` rises at E0 + (k+1)·(SETTLE+1).
- Counts and first-fail fields update on the CHECK exit edge and are stable whenever `done`=1.
- `start` held high in DONE retriggers a new sweep on the next edge.

## Test plan
- Config N_IN=3, N_OUT=1, SETTLE=2. DUT F=A&~B&C gives table 8'b0010_0000. Correct DUT, `start` pulse → `done` at start edge + 24 cycles, `pass_count`=8, `fail_count`=0, `pass`=1, `first_fail_valid`=0.
- Same table, DUT with bit 2 flipped (F=1 at A,B,C=0,1,0) → `fail_count`=1, `pass_count`=7, `first_fail_vec`=3'b010, `first_fail_got`=1'b1, `pass`=0.
- STOP_ON_FAIL=1, same faulty DUT → `done` at start edge + 9 cycles, `pass_count`=2, `fail_count`=1, `stim`=3'b010.
- `start` pulsed during SETTLE of vector 4 → sweep unaffected, totals as in the first scenario. Second `start` in DONE → counts cleared next edge, sweep repeats with identical results.
- `reset` asserted mid-sweep at vector 5 → same cycle: `busy`=0, `done`=0, counts 0, `stim`=0. After release, stays IDLE until `start`.
- N_IN=4, N_OUT=2, SETTLE=1, table all-zero, DUT outputs constant 2'b01 → `fail_count`=16 (5-bit, no wrap), `first_fail_vec`=4'b0000, `done` at start edge + 32 cycles.
